// File: rtl/telem_pkg.sv
// Shared types and constants for the telemetry framer.
// Frame layout: A5 5A SEQ LEN payload CHK.
package telem_pkg;

    localparam logic [7:0] SYNC0     = 8'hA5;
    localparam logic [7:0] SYNC1     = 8'h5A;
    localparam logic [7:0] CRC8_POLY = 8'h07;

    typedef enum logic [1:0] {
        IDLE,
        SNAP,
        EMIT,
        HOLD
    } state_t;

    // One full byte of CRC-8, MSB first, unrolled to 8 shift steps
    function automatic logic [7:0] crc8_step(
        input logic [7:0] crc,
        input logic [7:0] din
    );
        logic [7:0] c;
        c = crc ^ din;
        for (int i = 0; i < 8; i++) begin
            if (c[7]) c = {c[6:0], 1'b0} ^ CRC8_POLY;
            else      c = {c[6:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/telem_chk.sv
// Running frame check accumulator: XOR by default, CRC-8 when
// TELEMETRY_CRC8_EN is defined. clr restarts it at 0x00.
module telem_chk
    import telem_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] din,
    output logic [7:0] chk
);

    // Fold one byte per enabled clock into the accumulator
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            chk <= 8'h00;
        end else if (en) begin
`ifdef TELEMETRY_CRC8_EN
            chk <= crc8_step(chk, din);
`else
            chk <= chk ^ din;
`endif
        end
    end

endmodule

// File: rtl/telemetry_framer.sv
// N-channel telemetry packer feeding serial_tx byte by byte.
// Check byte is XOR, or CRC-8 when TELEMETRY_CRC8_EN is defined.
module telemetry_framer
    import telem_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int CH_BYTES      = 2,
    parameter int PERIOD_CYCLES = 5_000_000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH*CH_BYTES*8-1:0] ch_data,
    input  logic                         force_send,
    input  logic                         tx_busy,
    input  logic                         tx_block,
    output logic [7:0]                   tx_data,
    output logic                         new_data_tx,
    output logic                         frame_done,
    output logic [7:0]                   seq,
    output logic                         overrun
);

    localparam int LEN   = NUM_CH * CH_BYTES;
    localparam int TOTAL = LEN + 5;
    localparam int IDX_W = $clog2(TOTAL);
    localparam int TW    = $clog2(PERIOD_CYCLES);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(TOTAL - 1);
    localparam logic [TW-1:0]    TIMER_MAX = TW'(PERIOD_CYCLES - 1);
    localparam logic [7:0]       LEN_BYTE  = 8'(LEN);

    state_t           state;
    state_t           next_state;
    logic [TW-1:0]    timer;
    logic             pending;
    logic             trigger;
    logic [IDX_W-1:0] byte_idx;
    logic [7:0]       payload [LEN];
    logic [7:0]       shadow  [LEN];
    logic [7:0]       pay_byte;
    logic [7:0]       cur_byte;
    logic [7:0]       chk;
    logic             is_last;
    logic             tx_fire;
    logic             frame_end;
    logic             chk_en;

    assign trigger = force_send || (timer == TIMER_MAX);
    assign is_last = (byte_idx == LAST_IDX);
    assign chk_en  = tx_fire && (byte_idx >= IDX_W'(2)) && !is_last;

    // Free-running frame period timer
    always_ff @(posedge clk) begin
        if (rst) begin
            timer <= '0;
        end else if (timer == TIMER_MAX) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    // One-deep trigger queue; a second trigger while queued is sticky overrun
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (trigger && pending) overrun <= 1'b1;
            if (trigger) begin
                pending <= 1'b1;
            end else if (state == SNAP) begin
                pending <= 1'b0;
            end
        end
    end

    // Reorder the flat channel vector into transmit order (ch0 MSB first)
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            for (int b = 0; b < CH_BYTES; b++) begin
                payload[c*CH_BYTES+b] =
                    ch_data[(c*CH_BYTES+CH_BYTES-1-b)*8 +: 8];
            end
        end
    end

    // Snapshot channels so mid-frame changes never reach the wire
    always_ff @(posedge clk) begin
        if (state == SNAP) shadow <= payload;
    end

    // Select the payload byte for the current index
    always_comb begin
        pay_byte = 8'h00;
        for (int i = 0; i < LEN; i++) begin
            if (byte_idx == IDX_W'(i + 4)) pay_byte = shadow[i];
        end
    end

    // Byte decoder over the frame layout
    always_comb begin
        cur_byte = pay_byte;
        unique case (1'b1)
            byte_idx == IDX_W'(0): cur_byte = SYNC0;
            byte_idx == IDX_W'(1): cur_byte = SYNC1;
            byte_idx == IDX_W'(2): cur_byte = seq;
            byte_idx == IDX_W'(3): cur_byte = LEN_BYTE;
            is_last:               cur_byte = chk;
            default:               cur_byte = pay_byte;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // FSM next state and per-cycle actions
    always_comb begin
        next_state = state;
        tx_fire    = 1'b0;
        frame_end  = 1'b0;
        unique case (state)
            IDLE: begin
                if (pending) next_state = SNAP;
            end
            SNAP: begin
                next_state = EMIT;
            end
            EMIT: begin
                if (!tx_busy && !tx_block) begin
                    tx_fire    = 1'b1;
                    next_state = HOLD;
                end
            end
            HOLD: begin
                if (is_last) begin
                    frame_end  = 1'b1;
                    next_state = IDLE;
                end else begin
                    next_state = EMIT;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Registered byte strobe, frame index, done pulse and sequence number
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_data     <= 8'h00;
            new_data_tx <= 1'b0;
            frame_done  <= 1'b0;
            seq         <= 8'h00;
            byte_idx    <= '0;
        end else begin
            new_data_tx <= tx_fire;
            frame_done  <= frame_end;
            if (tx_fire) tx_data <= cur_byte;
            if (state == SNAP) begin
                byte_idx <= '0;
            end else if (state == HOLD && !is_last) begin
                byte_idx <= byte_idx + 1'b1;
            end
            if (frame_end) seq <= seq + 8'd1;
        end
    end

    telem_chk u_chk (
        .clk (clk),
        .rst (rst),
        .clr (state == SNAP),
        .en  (chk_en),
        .din (cur_byte),
        .chk (chk)
    );

endmodule
